// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3) for the 8-digit seven-segment driver.
// A conversion takes IN_W shift cycles plus one load cycle. num and ovf hold their values between conversions.
module bin_to_bcd_seq #(
  parameter int IN_W    = 27,
  parameter int DIGITS  = 8,
  parameter int MAX_VAL = 99999999
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic [4*DIGITS-1:0]   num,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  localparam int NUM_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam logic [IN_W-1:0] MAX_BIN = IN_W'(MAX_VAL);

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

  state_t             state, state_nx;
  logic [IN_W-1:0]    shreg;
  logic [NUM_W-1:0]   scratch, adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: every signal driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) state_nx = LOAD;
      LOAD:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // Digits are adjusted independently. A digit of 5..9 plus 3 fits in 4 bits, so no carry crosses into the next digit.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg    <= '0;
      scratch  <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      num      <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (bin > MAX_BIN) begin
              shreg    <= MAX_BIN;
              ovf_pend <= 1'b1;
            end else begin
              shreg    <= bin;
              ovf_pend <= 1'b0;
            end
            scratch <= '0;
            cnt     <= CNT_W'(IN_W);
          end
        end
        SHIFT: begin
          // Saturation keeps the value within 8 digits, so the bit shifted out of the top digit is always zero.
          scratch <= {adj[NUM_W-2:0], shreg[IN_W-1]};
          shreg   <= {shreg[IN_W-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
        end
        LOAD: begin
          num  <= scratch;
          ovf  <= ovf_pend;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: latency, hold, saturation, ignored start, mid-conversion reset, and a random sweep.
// Expected BCD words are hand-written for the directed cases. The random sweep uses a decimal-division model.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [26:0] bin = '0;
  logic [31:0] num;
  logic        busy, done, ovf;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] held = '0;

  bin_to_bcd_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .num   (num),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_bcd(input logic [26:0] v);
    int unsigned x;
    logic [31:0] r;
    x = (v > 27'd99999999) ? 99999999 : int'(v);
    r = '0;
    for (int i = 0; i < 8; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic nibbles_ok(input logic [31:0] w);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) if (w[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Starts one conversion and follows it cycle by cycle until done is seen.
  // If poke_k is positive, start is pulsed with poke_v after that cycle while the converter is busy.
  task automatic run_conv(input string tag, input logic [26:0] v, input logic [31:0] exp_num,
                          input logic exp_ovf, input int poke_k, input logic [26:0] poke_v);
    bit got;
    int lat;
    got = 1'b0;
    lat = 0;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = ~v;
    chk({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 40 && !got; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = k;
      end else begin
        chk({tag, "_hold"}, num, held);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, (k <= 26)});
        if (k == poke_k) begin
          start = 1'b1;
          bin   = poke_v;
        end
      end
    end
    chk({tag, "_done_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'd28);
    chk({tag, "_num"}, num, exp_num);
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    held = exp_num;
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic idle_check(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      chk({tag, "_no_done"}, {31'd0, done}, 32'd0);
      chk({tag, "_no_busy"}, {31'd0, busy}, 32'd0);
      chk({tag, "_held"}, num, held);
    end
  endtask

  initial begin
    logic [26:0] rv;
    logic [31:0] rexp;

    // Reset state
    #12;
    chk("rst_num", num, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle_check("post_rst", 3);

    // Zero, typical values and hold-until-done
    run_conv("zero", 27'd0, 32'h00000000, 1'b0, -1, '0);
    run_conv("v12345678", 27'd12345678, 32'h12345678, 1'b0, -1, '0);
    idle_check("gap", 4);
    run_conv("v905", 27'd905, 32'h00000905, 1'b0, -1, '0);

    // Saturation boundaries
    run_conv("max", 27'd99999999, 32'h99999999, 1'b0, -1, '0);
    run_conv("max_p1", 27'd100000000, 32'h99999999, 1'b1, -1, '0);
    run_conv("all_ones", 27'd134217727, 32'h99999999, 1'b1, -1, '0);
    run_conv("v7", 27'd7, 32'h00000007, 1'b0, -1, '0);

    // start while busy is ignored
    run_conv("v42_poke", 27'd42, 32'h00000042, 1'b0, 10, 27'd77);
    idle_check("after_poke", 30);

    // Reset mid-conversion aborts without a done pulse
    @(negedge clk);
    bin   = 27'd555;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("midrst_num", num, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    held = 32'h0;
    idle_check("post_midrst", 35);
    run_conv("v555", 27'd555, 32'h00000555, 1'b0, -1, '0);

    // Random sweep against the decimal model
    for (int i = 0; i < 1000; i++) begin
      rv   = 27'($urandom);
      rexp = ref_bcd(rv);
      run_conv("rand", rv, rexp, (rv > 27'd99999999), -1, '0);
      chk("rand_nibbles", {31'd0, nibbles_ok(num)}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
